uop_sequencer: RTL and testbench

Microcode sequencer for the curve point-arithmetic engine. Fetches 20-bit micro-operations from a synchronous microprogram ROM (doubling or addition), decodes them, issues each to the modular-arithmetic datapath with a start/done handshake, and evaluates per-uop execution conditions from a latched compare flag. Sits between the curve top-level controller (start/ready) and the ROM plus datapath.

---
 rtl/uop_sequencer.sv | 147 ++++++++++++++
 tb/tb_uop_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_sequencer.sv
// Microcode sequencer: fetches microwords from a synchronous ROM and issues them to the datapath.
// Latency: ena to first op_start is 3 edges; a skipped uop takes 2 cycles, an issued uop 2+N cycles.
// Backpressure: holds each uop in WAIT until op_done; ena is ignored while busy.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena / rdy / err     start request, idle indication, sticky error
//   rom_addr / rom_data registered ROM address, word valid one cycle later
//   op_start, op_code, op_src_a, op_src_b, op_dst   issue strobe and held uop fields
//   op_done, cmp_eq     datapath completion and compare result
module uop_sequencer #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              rdy,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              op_start,
  output logic [3:0]        op_code,
  output logic [4:0]        op_src_a,
  output logic [4:0]        op_src_b,
  output logic [3:0]        op_dst,
  input  logic              op_done,
  input  logic              cmp_eq
);

  localparam logic [3:0] OP_RDY = 4'd0;
  localparam logic [3:0] OP_CMP = 4'd1;
  localparam logic [3:0] OP_MAX = 4'd5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT
  } state_t;

  state_t state;
  logic   flag;

  // Microword fields, meaningful only while in DECODE.
  logic [3:0] w_op;
  logic [4:0] w_src_a;
  logic [4:0] w_src_b;
  logic [3:0] w_dst;
  logic [1:0] w_exec;
  logic       exec_ok;
  logic       at_last;

  assign w_op    = rom_data[19:16];
  assign w_src_a = rom_data[15:11];
  assign w_src_b = rom_data[10:6];
  assign w_dst   = rom_data[5:2];
  assign w_exec  = rom_data[1:0];
  assign at_last = (rom_addr == LAST_ADDR);

  always_comb begin
    exec_ok = 1'b0;
    case (w_exec)
      2'b00:   exec_ok = 1'b1;
      2'b01:   exec_ok = flag;
      2'b10:   exec_ok = ~flag;
      default: exec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rdy      <= 1'b1;
      err      <= 1'b0;
      flag     <= 1'b0;
      rom_addr <= '0;
      op_start <= 1'b0;
      op_code  <= '0;
      op_src_a <= '0;
      op_src_b <= '0;
      op_dst   <= '0;
    end else begin
      op_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena) begin
            rom_addr <= '0;
            flag     <= 1'b0;
            err      <= 1'b0;
            rdy      <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          if (w_op == OP_RDY) begin
            rdy   <= 1'b1;
            state <= S_IDLE;
          end else if (w_op > OP_MAX) begin
            err   <= 1'b1;
            rdy   <= 1'b1;
            state <= S_IDLE;
          end else if (!exec_ok) begin
            // Skipped uop advances exactly like a completed one.
            if (at_last) begin
              err   <= 1'b1;
              rdy   <= 1'b1;
              state <= S_IDLE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            op_code  <= w_op;
            op_src_a <= w_src_a;
            op_src_b <= w_src_b;
            op_dst   <= w_dst;
            op_start <= 1'b1;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (op_done) begin
            if (op_code == OP_CMP) flag <= cmp_eq;
            // Running off the end of the ROM is an error rather than a wrap.
            if (at_last) begin
              err   <= 1'b1;
              rdy   <= 1'b1;
              state <= S_IDLE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= S_FETCH;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboarded bench for uop_sequencer with a synchronous ROM model and a
// fixed-latency datapath model driving op_done.
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        rdy;
  logic        err;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data = '0;
  logic        op_start;
  logic [3:0]  op_code;
  logic [4:0]  op_src_a;
  logic [4:0]  op_src_b;
  logic [3:0]  op_dst;
  logic        op_done;
  logic        cmp_eq;

  logic        dp_done = 1'b0;
  logic        spur = 1'b0;
  logic        cmp_val = 1'b0;
  int          dp_lat = 1;
  int          rem = 0;
  int          op_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  logic [19:0] rom [64];

  typedef struct {
    logic [3:0] code;
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] d;
    bit         chk_b;
  } exp_t;
  exp_t sb_q[$];

  assign op_done = dp_done | spur;
  assign cmp_eq  = cmp_val;

  uop_sequencer #(.ADDR_W(6), .WORD_W(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .rdy      (rdy),
    .err      (err),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .op_start (op_start),
    .op_code  (op_code),
    .op_src_a (op_src_a),
    .op_src_b (op_src_b),
    .op_dst   (op_dst),
    .op_done  (op_done),
    .cmp_eq   (cmp_eq)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word appears one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input int op, input int a, input int b,
                                      input int d, input int ex);
    return {op[3:0], a[4:0], b[4:0], d[3:0], ex[1:0]};
  endfunction

  task automatic push_exp(input int code, input int a, input int b, input int d,
                          input bit chk_b);
    exp_t e;
    e.code = code[3:0]; e.a = a[4:0]; e.b = b[4:0]; e.d = d[3:0]; e.chk_b = chk_b;
    sb_q.push_back(e);
  endtask

  task automatic fill_rom(input logic [19:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  // Monitor plus datapath model, both evaluated away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    dp_done = 1'b0;
    if (!rst_n) rem = 0;
    if (op_start) begin
      op_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected op_start code=%0d with empty scoreboard", op_code);
      end else begin
        e = sb_q.pop_front();
        chk("sb_code", op_code, e.code);
        chk("sb_src_a", op_src_a, e.a);
        if (e.chk_b) chk("sb_src_b", op_src_b, e.b);
        chk("sb_dst", op_dst, e.d);
      end
      rem = dp_lat;
    end
    if (rem > 0) begin
      rem--;
      if (rem == 0) dp_done = 1'b1;
    end
  end

  // Pulse ena for edge 0 and return the edge number after which rdy is high.
  task automatic run(input int maxc, output int edge_n);
    @(negedge clk);
    ena = 1'b1;
    edge_n = -1;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      ena = 1'b0;
      if (rdy) begin
        edge_n = n - 1;
        break;
      end
    end
  endtask

  initial begin
    int e;
    fill_rom(20'h0);
    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_err", err, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_op_start", op_start, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_src_a", op_src_a, 0);
    chk("rst_src_b", op_src_b, 0);
    chk("rst_dst", op_dst, 0);
    rst_n = 1'b1;

    // Program {0: RDY}
    op_cnt = 0;
    run(20, e);
    chk("rdy_only_edge", e, 2);
    chk("rdy_only_err", err, 0);
    chk("rdy_only_addr", rom_addr, 0);
    chk("rdy_only_ops", op_cnt, 0);

    // MOV, ADD, RDY with 3-cycle datapath
    fill_rom(20'h0);
    rom[0] = mk(2, 3, 0, 2, 0);
    rom[1] = mk(3, 3, 4, 5, 0);
    dp_lat = 3;
    push_exp(2, 3, 0, 2, 1'b0);
    push_exp(3, 3, 4, 5, 1'b1);
    op_cnt = 0;
    run(50, e);
    chk("prog2_edge", e, 12);
    chk("prog2_ops", op_cnt, 2);
    chk("prog2_err", err, 0);
    chk("prog2_addr", rom_addr, 2);
    chk("prog2_drain", sb_q.size(), 0);

    // Conditional execution, cmp_eq = 1
    fill_rom(20'h0);
    rom[0] = mk(1, 1, 2, 0, 0);
    rom[1] = mk(2, 5, 0, 6, 1);
    rom[2] = mk(2, 7, 0, 8, 2);
    dp_lat = 1;
    cmp_val = 1'b1;
    push_exp(1, 1, 2, 0, 1'b1);
    push_exp(2, 5, 0, 6, 1'b1);
    op_cnt = 0;
    run(50, e);
    chk("cond1_edge", e, 10);
    chk("cond1_ops", op_cnt, 2);
    chk("cond1_drain", sb_q.size(), 0);

    // flag is left at 1; a fresh run must start with it cleared
    fill_rom(20'h0);
    rom[0] = mk(2, 9, 0, 9, 1);
    op_cnt = 0;
    run(20, e);
    chk("flagclr_edge", e, 4);
    chk("flagclr_ops", op_cnt, 0);

    // Conditional execution, cmp_eq = 0
    fill_rom(20'h0);
    rom[0] = mk(1, 1, 2, 0, 0);
    rom[1] = mk(2, 5, 0, 6, 1);
    rom[2] = mk(2, 7, 0, 8, 2);
    cmp_val = 1'b0;
    push_exp(1, 1, 2, 0, 1'b1);
    push_exp(2, 7, 0, 8, 1'b1);
    op_cnt = 0;
    run(50, e);
    chk("cond0_edge", e, 10);
    chk("cond0_ops", op_cnt, 2);
    chk("cond0_drain", sb_q.size(), 0);

    // Illegal opcode 9 at address 1
    fill_rom(20'h0);
    rom[0] = mk(2, 4, 0, 1, 0);
    rom[1] = mk(9, 1, 1, 1, 0);
    push_exp(2, 4, 0, 1, 1'b0);
    op_cnt = 0;
    run(50, e);
    chk("illegal_edge", e, 5);
    chk("illegal_err", err, 1);
    chk("illegal_ops", op_cnt, 1);
    chk("illegal_addr", rom_addr, 1);
    fill_rom(20'h0);
    run(20, e);
    chk("errclr_edge", e, 2);
    chk("errclr_err", err, 0);

    // 64 skipped uops, no RDY: runs off the end
    fill_rom(mk(2, 1, 1, 1, 3));
    op_cnt = 0;
    run(300, e);
    chk("walk_edge", e, 128);
    chk("walk_err", err, 1);
    chk("walk_addr", rom_addr, 63);
    chk("walk_ops", op_cnt, 0);

    // Reset during WAIT of a MUL
    fill_rom(20'h0);
    rom[0] = mk(5, 1, 2, 3, 0);
    dp_lat = 50;
    push_exp(5, 1, 2, 3, 1'b1);
    op_cnt = 0;
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    for (int n = 0; n < 10 && op_cnt == 0; n++) @(negedge clk);
    chk("mul_issued", op_cnt, 1);
    @(negedge clk);
    chk("mul_busy", rdy, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", rdy, 1);
    chk("arst_code", op_code, 0);
    chk("arst_src_a", op_src_a, 0);
    chk("arst_src_b", op_src_b, 0);
    chk("arst_dst", op_dst, 0);
    chk("arst_addr", rom_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("arst_drain", sb_q.size(), 0);

    // ena held through the run, spurious op_done while in FETCH
    fill_rom(20'h0);
    rom[0] = mk(2, 6, 0, 7, 0);
    dp_lat = 2;
    push_exp(2, 6, 0, 7, 1'b0);
    op_cnt = 0;
    @(negedge clk);
    ena = 1'b1;
    e = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      spur = (n == 1);
      if (rdy) begin
        e = n - 1;
        break;
      end
    end
    ena = 1'b0;
    spur = 1'b0;
    chk("hold_edge", e, 6);
    chk("hold_ops", op_cnt, 1);
    chk("hold_addr", rom_addr, 1);
    repeat (3) @(negedge clk);
    chk("hold_idle", rdy, 1);
    chk("hold_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
